// File: rtl/segled_pkg.sv
// segled_pkg: shared types and constants for the multiplexed 7-segment driver.
//   seg_t   : 7-bit segment vector {g,f,e,d,c,b,a}, active-high
//   SEG_HEX : hex digit 0..F -> active-high segment pattern
package segled_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_hex_dec.sv
// seg7_hex_dec: combinational hex nibble to 7-segment lookup.
//   nib  : input nibble 0..F
//   segs : active-high segments {g,f,e,d,c,b,a}
module seg7_hex_dec
    import segled_pkg::*;
(
    input  logic [3:0] nib,
    output seg_t       segs
);

    always_comb begin
        segs = SEG_HEX[nib];
    end

endmodule

// File: rtl/segled_scan.sv
// segled_scan: time-multiplexed N-digit hex 7-segment display driver.
//   clk, rst_n   : clock, synchronous active-low reset
//   en           : scan enable (outputs dark and scan position frozen when low)
//   load         : one-cycle strobe capturing data/dp/blank/lzb_en into staging
//   data         : packed nibbles, digit 0 in data[3:0]
//   dp, blank    : per-digit decimal point and force-dark masks
//   lzb_en       : leading-zero blanking enable, captured with load
//   segs, dp_o   : segment and decimal point drive
//   digit_sel    : one-hot digit enable
//   frame_tick   : one-cycle pulse when the scan wraps to digit 0
// Polarity of segs/dp_o/digit_sel follows COMMON_ANODE (1 = active-low).
module segled_scan
    import segled_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 1024,
    parameter int BLANK_CYC    = 16,
    parameter int COMMON_ANODE = 0
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                load,
    input  logic [4*DIGITS-1:0] data,
    input  logic [DIGITS-1:0]   dp,
    input  logic [DIGITS-1:0]   blank,
    input  logic                lzb_en,
    output logic [6:0]          segs,
    output logic                dp_o,
    output logic [DIGITS-1:0]   digit_sel,
    output logic                frame_tick
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);
    localparam logic          INV      = (COMMON_ANODE != 0);

    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] stg_data_q, stg_data_d, act_data_q, act_data_d;
    logic [DIGITS-1:0]   stg_dp_q, stg_dp_d, act_dp_q, act_dp_d;
    logic [DIGITS-1:0]   stg_blank_q, stg_blank_d, act_blank_q, act_blank_d;
    logic                stg_lzb_q, stg_lzb_d, act_lzb_q, act_lzb_d;
    logic                pending_q, pending_d;
    logic [6:0]          segs_q, segs_d;
    logic                dp_o_q, dp_o_d;
    logic [DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic                frame_tick_q, frame_tick_d;

    logic                pcnt_wrap, frame_wrap, xfer;
    logic                lead, dp_sel, dark, in_gap, dp_lit;
    logic [DIGITS-1:0]   lz, sel_hot, sel_lit;
    logic [3:0]          nib_sel;
    seg_t                seg_raw, seg_lit;

    // Scan position and double-buffered register file.
    always_comb begin
        pcnt_wrap  = en && (pcnt_q == PCNT_MAX);
        frame_wrap = pcnt_wrap && (idx_q == IDX_MAX);
        // Active regs may only change between frames, or at any time while idle.
        xfer       = frame_wrap || !en;

        pcnt_d = pcnt_q;
        idx_d  = idx_q;
        if (en) begin
            if (pcnt_wrap) begin
                pcnt_d = '0;
                idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end

        stg_data_d  = stg_data_q;
        stg_dp_d    = stg_dp_q;
        stg_blank_d = stg_blank_q;
        stg_lzb_d   = stg_lzb_q;
        if (load) begin
            stg_data_d  = data;
            stg_dp_d    = dp;
            stg_blank_d = blank;
            stg_lzb_d   = lzb_en;
        end

        // Transfer from the post-load staging value so a load on the wrap
        // edge lands in the active regs directly.
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        act_lzb_d   = act_lzb_q;
        pending_d   = pending_q || load;
        if (pending_d && xfer) begin
            act_data_d  = stg_data_d;
            act_dp_d    = stg_dp_d;
            act_blank_d = stg_blank_d;
            act_lzb_d   = stg_lzb_d;
            pending_d   = 1'b0;
        end

        frame_tick_d = frame_wrap;
    end

    // Leading-zero mask and per-digit selection, evaluated on next-state
    // values so the registered outputs line up with pcnt/idx.
    always_comb begin
        lead = act_lzb_d;
        lz   = '0;
        for (int unsigned k = 1; k < DIGITS; k++) begin
            if (lead && (act_data_d[4*(DIGITS-k) +: 4] == 4'h0) && !act_dp_d[DIGITS-k]) begin
                lz[DIGITS-k] = 1'b1;
            end else begin
                lead = 1'b0;
            end
        end

        nib_sel = '0;
        dp_sel  = 1'b0;
        dark    = 1'b0;
        sel_hot = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                nib_sel    = act_data_d[4*i +: 4];
                dp_sel     = act_dp_d[i];
                dark       = act_blank_d[i] | lz[i];
                sel_hot[i] = 1'b1;
            end
        end
    end

    generate
        if (BLANK_CYC > 0) begin : g_gap
            always_comb in_gap = (pcnt_d < PW'(BLANK_CYC));
        end else begin : g_nogap
            always_comb in_gap = 1'b0;
        end
    endgenerate

    seg7_hex_dec u_dec (
        .nib  (nib_sel),
        .segs (seg_raw)
    );

    always_comb begin
        seg_lit = '0;
        dp_lit  = 1'b0;
        sel_lit = '0;
        if (en && !in_gap) begin
            sel_lit = sel_hot;
            if (!dark) begin
                seg_lit = seg_raw;
                dp_lit  = dp_sel;
            end
        end
        segs_d      = seg_lit ^ {7{INV}};
        dp_o_d      = dp_lit ^ INV;
        digit_sel_d = sel_lit ^ {DIGITS{INV}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_q       <= '0;
            idx_q        <= '0;
            stg_data_q   <= '0;
            stg_dp_q     <= '0;
            stg_blank_q  <= '0;
            stg_lzb_q    <= 1'b0;
            pending_q    <= 1'b0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            act_lzb_q    <= 1'b0;
            segs_q       <= {7{INV}};
            dp_o_q       <= INV;
            digit_sel_q  <= {DIGITS{INV}};
            frame_tick_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            stg_data_q   <= stg_data_d;
            stg_dp_q     <= stg_dp_d;
            stg_blank_q  <= stg_blank_d;
            stg_lzb_q    <= stg_lzb_d;
            pending_q    <= pending_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            act_lzb_q    <= act_lzb_d;
            segs_q       <= segs_d;
            dp_o_q       <= dp_o_d;
            digit_sel_q  <= digit_sel_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign segs       = segs_q;
    assign dp_o       = dp_o_q;
    assign digit_sel  = digit_sel_q;
    assign frame_tick = frame_tick_q;

endmodule
